// File: rtl/crossbar_pkg.sv
// crossbar_pkg: shared FSM state, command encodings and slave decode for the crossbar
package crossbar_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, WAIT_RESP} state_t;
  localparam logic CMD_READ = 1'b0;
  localparam logic CMD_WRITE = 1'b1;
  // Top $clog2(n) address bits, right-aligned, name the target slave.
  function automatic logic [31:0] slave_sel(input logic [31:0] addr, input int n);
    return addr >> (32 - $clog2(n));
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or above ptr, wrapping
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] win_o,
  output logic         any_o
);
  // Scan offsets from the top down so the smallest offset from ptr lands last and wins.
  always_comb begin
    win_o = ptr_i;
    for (int k = N - 1; k >= 0; k--) if (req_i[ptr_i + W'(k)]) win_o = ptr_i + W'(k);
  end
  assign any_o = |req_i;
endmodule

// File: rtl/crossbar_slave_arbiter.sv
// crossbar_slave_arbiter: per-slave round-robin arbitration and request/response routing
module crossbar_slave_arbiter
  import crossbar_pkg::*;
#(
  parameter int N = 4,
  parameter int SLAVE_ID = 0,
  parameter int AW = 32 - $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         m_req,
  input  logic [N-1:0]         m_cmd,
  input  logic [31:0]          m_addr [N],
  input  logic [31:0]          m_wdata [N],
  output logic [N-1:0]         m_ack,
  output logic [N-1:0]         m_resp,
  output logic [31:0]          m_rdata [N],
  output logic                 s_req,
  output logic                 s_cmd,
  output logic [AW-1:0]        s_addr,
  output logic [31:0]          s_wdata,
  input  logic                 s_ack,
  input  logic                 s_resp,
  input  logic [31:0]          s_rdata,
  output logic                 busy,
  output logic [$clog2(N)-1:0] grant_idx
);
  localparam int W = $clog2(N);
  state_t state_q;
  logic [W-1:0] ptr_q, grant_q, win;
  logic [N-1:0] tgt;
  logic any_req, g_ok, in_grant, in_wait;
  always_comb for (int i = 0; i < N; i++) tgt[i] = m_req[i] && slave_sel(m_addr[i], N) == 32'(SLAVE_ID);
  rr_arbiter #(.N(N)) u_rr (.req_i(tgt), .ptr_i(ptr_q), .win_o(win), .any_o(any_req));
  assign in_grant = state_q == GRANT;
  assign in_wait = state_q == WAIT_RESP;
  assign g_ok = tgt[grant_q];
  assign s_req = in_grant && g_ok;
  assign s_cmd = in_grant ? m_cmd[grant_q] : 1'b0;
  assign s_addr = in_grant ? m_addr[grant_q][AW-1:0] : '0;
  assign s_wdata = in_grant ? m_wdata[grant_q] : '0;
  assign busy = state_q != IDLE;
  assign grant_idx = grant_q;
  // Only the granted master ever sees ack/resp; stray slave handshakes fall on the floor.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      m_ack[i] = W'(i) == grant_q && s_req && s_ack;
      m_resp[i] = W'(i) == grant_q && in_wait && s_resp;
      m_rdata[i] = m_resp[i] ? s_rdata : '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      grant_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          grant_q <= win;
          state_q <= GRANT;
        end
        // A request withdrawn or retargeted before ack is abandoned without advancing ptr.
        GRANT: if (!g_ok) state_q <= IDLE;
        else if (s_ack) begin
          if (m_cmd[grant_q] == CMD_WRITE) begin
            state_q <= IDLE;
            ptr_q <= grant_q + W'(1);
          end else state_q <= WAIT_RESP;
        end
        WAIT_RESP: if (s_resp) begin
          state_q <= IDLE;
          ptr_q <= grant_q + W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/crossbar_slave_arbiter.md
# crossbar_slave_arbiter

Per-slave arbitration and routing stage of the N×N crossbar. One instance per slave port. It selects among the masters whose address targets this slave using round-robin, and forwards the winner's request to the slave. Ack, response and read data are routed back to that master only. The grant is held until the transaction completes.

## Interface
Parameters:
- N, 4, number of masters and slaves; power of two, N ≥ 2
- SLAVE_ID, 0, index of the slave this instance serves; range 0..N-1
- AW, 32-$clog2(N), slave-side address width (derived; do not override)

Ports:
- clk  input  1  clock; everything is sampled on the rising edge
- rst  input  1  reset; asynchronous, active-high
- m_req[N]  input  1 each  master request
- m_cmd[N]  input  1 each  master command: 0 = read, 1 = write
- m_addr[N]  input  32 each  master address; bits [31:AW] select the slave
- m_wdata[N]  input  32 each  master write data
- m_ack[N]  output  1 each  request accepted, returned to the master
- m_resp[N]  output  1 each  read data valid, returned to the master
- m_rdata[N]  output  32 each  read data, returned to the master
- s_req  output  1  request to the slave
- s_cmd  output  1  command to the slave
- s_addr  output  AW  slave-local address, m_addr[grant][AW-1:0]
- s_wdata  output  32  write data to the slave
- s_ack  input  1  slave accepted the request
- s_resp  input  1  slave read data valid
- s_rdata  input  32  slave read data
- busy  output  1  high whenever state ≠ IDLE
- grant_idx  output  $clog2(N)  currently granted master; valid only while busy

## Operation
Targeting:
- Master i targets this instance when m_req[i] = 1 and m_addr[i][31:AW] = SLAVE_ID.
- The request vector is the set of masters that target this instance.

State machine, enum {IDLE, GRANT, WAIT_RESP}:
- **IDLE**
  - If any bit of the request vector is set, the rr_arbiter picks a winner.
  - The winner is the first set bit at or above ptr, searching upward with wrap-around.
  - Register the winner into grant_idx and go to GRANT.
  - With no requests, stay in IDLE.
- **GRANT**
  - s_req = m_req[grant_idx] AND the grant still targets this slave.
  - s_cmd, s_addr and s_wdata come from master grant_idx.
  - m_ack[grant_idx] = s_ack, combinational.
  - On s_req & s_ack:
    - write: go to IDLE and set ptr = grant_idx+1 (mod N).
    - read: go to WAIT_RESP.
  - If the granted master drops its request, or retargets, before ack: go to IDLE with ptr unchanged (abandoned request).
- **WAIT_RESP**
  - s_req = 0.
  - m_resp[grant_idx] = s_resp and m_rdata[grant_idx] = s_rdata.
  - On s_resp: go to IDLE and set ptr = grant_idx+1 (mod N).

Routing of non-granted masters and idle outputs:
- Non-granted masters always see m_ack = 0, m_resp = 0 and m_rdata = 0.
- Outside GRANT, s_cmd, s_addr and s_wdata are 0.

Illegal responses:
- s_ack outside GRANT is ignored.
- s_resp outside WAIT_RESP is ignored and never routed to any master.

Reset:
- Asserting rst forces state = IDLE, ptr = 0, grant_idx = 0 and busy = 0.
- All outputs go to 0 immediately, including mid-transaction.
- An in-flight read is dropped; its master receives no resp.

## Timing
- Arbitration costs 1 cycle: a request first seen in IDLE at edge k drives s_req from cycle k+1.
- Ack is combinational with zero added latency. The master sees ack in the same cycle the slave asserts it.
- A write completes on the ack cycle. The arbiter returns to IDLE in the next cycle, and a new grant can be issued one cycle after that.
- A read completes on the resp cycle. Resp and rdata are combinational pass-through.
- Minimum occupancy is 2 cycles per write (GRANT with immediate ack, then IDLE). For a read it is 3 cycles plus the slave's resp latency.
- Round-robin fairness: with all N masters requesting continuously, each is granted exactly once in any N consecutive grants.
- ptr updates only on completion. Abandoned requests do not advance it.
- Multiple masters targeting this slave in the same cycle: exactly one wins. The rest see m_ack = 0 until they are granted.

## Structure
- Package crossbar_pkg holds:
  - state_t enum {IDLE, GRANT, WAIT_RESP}
  - CMD_READ = 1'b0 and CMD_WRITE = 1'b1
  - function slave_sel(addr, N), returning addr[31 -: $clog2(N)]
- Sub-module rr_arbiter #(N):
  - Purely combinational.
  - Inputs: request vector and ptr.
  - Outputs: winner index and any_req.
  - Reusable by a future master-side response arbiter.
- The top crossbar instantiates N copies of crossbar_slave_arbiter with SLAVE_ID = 0..N-1.

## Test plan
All cases use N = 4 and SLAVE_ID = 2.
1. Master 1 writes addr 0x8000_0010, wdata 0xDEAD_BEEF; the slave acks on the first GRANT cycle.
   - Required: s_addr = 0x0000_0010 and s_wdata = 0xDEAD_BEEF.
   - Required: m_ack[1] pulses once and busy falls the next cycle.
2. Master 3 reads; the slave acks, then pulses resp 5 cycles later with 0x1234_5678.
   - Required: m_resp[3] = 1 and m_rdata[3] = 0x1234_5678 in that same cycle.
   - Required: all other masters stay at 0.
3. Masters 0–3 all request slave 2 continuously for 8 writes.
   - Required grant order: 0,1,2,3,0,1,2,3.
4. Master 0 targets slave 1 while master 2 targets slave 2.
   - Required: only master 2 is granted; master 0 never sees ack from this instance.
5. Assert rst during WAIT_RESP, then pulse s_resp.
   - Required: all outputs go to 0 immediately; no m_resp is generated.
   - Required: after reset, ptr = 0, so master 0 wins the next contention.
6. The granted master drops req before the slave acks.
   - Required: return to IDLE with ptr unchanged; the same master wins the next identical contention.
